// File: rtl/alu_result_stage_pkg.sv
// Shared types and constants for the ALU result stage.
package alu_result_stage_pkg;

    // Default datapath width of one SIMD result.
    localparam int unsigned DefaultWidth = 8;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_result_stage_pattern_detect.sv
// Masked pattern compare: exact match and complement match. A mask bit of 1 ignores that bit.
module alu_pattern_detect
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
    input  logic [Width-1:0] i_data,
    input  logic [Width-1:0] i_pattern,
    input  logic [Width-1:0] i_mask,
    output logic             o_match,
    output logic             o_match_b
);

    assign o_match   = ((i_data ^ i_pattern) & ~i_mask) == '0;
    assign o_match_b = ((i_data ^ ~i_pattern) & ~i_mask) == '0;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result register stage: two-entry skid buffer carrying the result, its carry-out and the
// pattern-detect / overflow / underflow flags, plus the accumulator feedback register.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] S,
    input  logic [1:0]       result_SIMD_carry_out,
    input  logic [Width-1:0] pattern,
    input  logic [Width-1:0] mask,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] P,
    output logic [1:0]       P_carry,
    output logic             pattern_detect,
    output logic             pattern_b_detect,
    output logic             overflow,
    output logic             underflow,
    output logic [Width-1:0] P_feedback
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;

    // Head entry (drives the outputs) and skid entry (second slot).
    logic [Width-1:0] r_p;
    logic [1:0]       r_p_carry;
    logic             r_pd, r_pbd, r_ovf, r_unf;
    logic [Width-1:0] r_sk_p;
    logic [1:0]       r_sk_carry;
    logic             r_sk_pd, r_sk_pbd, r_sk_ovf, r_sk_unf;

    logic [Width-1:0] r_feedback;
    logic             r_hist_pd;
    logic             r_hist_pbd;

    logic             w_accept;
    logic             w_pop;
    logic             w_pd;
    logic             w_pbd;
    logic             w_prev_pd;
    logic             w_prev_pbd;
    logic             w_ovf;
    logic             w_unf;
    logic             w_load_head;
    logic             w_head_from_skid;
    logic             w_load_skid;

    alu_pattern_detect #(
        .Width (Width)
    ) u_pattern_detect (
        .i_data    (S),
        .i_pattern (pattern),
        .i_mask    (mask),
        .o_match   (w_pd),
        .o_match_b (w_pbd)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_out_valid & out_ready;

    // A coincident clear wipes the history before the new entry is compared against it.
    assign w_prev_pd  = r_hist_pd & ~acc_clear;
    assign w_prev_pbd = r_hist_pbd & ~acc_clear;
    assign w_ovf      = w_prev_pd & ~w_pd & ~w_pbd & ~S[Width-1];
    assign w_unf      = w_prev_pbd & ~w_pd & ~w_pbd & S[Width-1];

    // Next buffer occupancy and which slot each accepted/retired entry moves through.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head      = 1'b0;
        w_head_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            StEmpty: begin
                if (w_accept) begin
                    w_state_nxt = StOne;
                    w_load_head = 1'b1;
                end
            end
            StOne: begin
                if (w_accept && w_pop) begin
                    w_load_head = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = StTwo;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_state_nxt      = StOne;
                    w_load_head      = 1'b1;
                    w_head_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = StEmpty;
        endcase
    end

    // Buffer state, registered handshakes, entry storage, feedback and detect history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StEmpty;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_p         <= '0;
            r_p_carry   <= '0;
            r_pd        <= 1'b0;
            r_pbd       <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_sk_p      <= '0;
            r_sk_carry  <= '0;
            r_sk_pd     <= 1'b0;
            r_sk_pbd    <= 1'b0;
            r_sk_ovf    <= 1'b0;
            r_sk_unf    <= 1'b0;
            r_feedback  <= '0;
            r_hist_pd   <= 1'b0;
            r_hist_pbd  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != StTwo);
            r_out_valid <= (w_state_nxt != StEmpty);

            if (w_load_head) begin
                if (w_head_from_skid) begin
                    r_p       <= r_sk_p;
                    r_p_carry <= r_sk_carry;
                    r_pd      <= r_sk_pd;
                    r_pbd     <= r_sk_pbd;
                    r_ovf     <= r_sk_ovf;
                    r_unf     <= r_sk_unf;
                end else begin
                    r_p       <= S;
                    r_p_carry <= result_SIMD_carry_out;
                    r_pd      <= w_pd;
                    r_pbd     <= w_pbd;
                    r_ovf     <= w_ovf;
                    r_unf     <= w_unf;
                end
            end

            if (w_load_skid) begin
                r_sk_p     <= S;
                r_sk_carry <= result_SIMD_carry_out;
                r_sk_pd    <= w_pd;
                r_sk_pbd   <= w_pbd;
                r_sk_ovf   <= w_ovf;
                r_sk_unf   <= w_unf;
            end

            // Acceptance wins over clear: the new entry becomes the history and the feedback.
            if (w_accept) begin
                r_feedback <= S;
                r_hist_pd  <= w_pd;
                r_hist_pbd <= w_pbd;
            end else if (acc_clear) begin
                r_feedback <= '0;
                r_hist_pd  <= 1'b0;
                r_hist_pbd <= 1'b0;
            end
        end
    end

    assign in_ready         = r_in_ready;
    assign out_valid        = r_out_valid;
    assign P                = r_p;
    assign P_carry          = r_p_carry;
    assign pattern_detect   = r_pd;
    assign pattern_b_detect = r_pbd;
    assign overflow         = r_ovf;
    assign underflow        = r_unf;
    assign P_feedback       = r_feedback;

endmodule
